// File: rtl/regs_cmd_parser.sv
// Byte-stream command parser feeding the register file: framed read/write commands in, one-hot strobes out.
// Optional inter-byte timeout while waiting for write data is enabled by defining REGS_CMD_TIMEOUT_EN.
module regs_cmd_parser #(
    parameter int unsigned N       = 26,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [7:0]   master_data,
    output logic [N-1:0] valid_bus,
    output logic [N-1:0] rdreq_bus,
    input  logic [7:0]   slave_data,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         err
);

    if (N < 1 || N > 128 || TIMEOUT < 1) begin : g_param_check
        $error("regs_cmd_parser: N must be 1..128 and TIMEOUT at least 1");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        WRITE     = 3'd2,
        READ      = 3'd3,
        SEND      = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [6:0]     addr;
    logic [6:0]     addr_d;
    logic [7:0]     master_data_d;
    logic [7:0]     tx_data_d;
    logic [N-1:0]   valid_bus_d;
    logic [N-1:0]   rdreq_bus_d;
    logic           rx_ready_d;
    logic           tx_valid_d;
    logic           err_d;
    logic           rx_fire_c;
    logic           cmd_ok_c;
    logic           addr_ok_c;
    logic           timeout_c;

    assign rx_fire_c = rx_valid && rx_ready;
    assign cmd_ok_c  = 32'(rx_data[6:0]) < N;
    assign addr_ok_c = 32'(addr) < N;

`ifdef REGS_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Counts idle cycles in WAIT_DATA; any accepted byte or other state clears it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_cnt <= '0;
        end else if (state != WAIT_DATA || rx_fire_c) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign timeout_c = (state == WAIT_DATA) && !rx_fire_c && (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (rx_fire_c) state_nxt = rx_data[7] ? WAIT_DATA : READ;
            WAIT_DATA: begin
                if (rx_fire_c) begin
                    state_nxt = WRITE;
                end else if (timeout_c) begin
                    state_nxt = IDLE;
                end
            end
            WRITE:     state_nxt = IDLE;
            READ:      state_nxt = SEND;
            SEND:      if (tx_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the transition being taken.
    always_comb begin
        rx_ready_d    = (state_nxt == IDLE) || (state_nxt == WAIT_DATA);
        tx_valid_d    = (state_nxt == SEND);
        valid_bus_d   = '0;
        rdreq_bus_d   = '0;
        err_d         = 1'b0;
        addr_d        = addr;
        master_data_d = master_data;
        tx_data_d     = tx_data;

        if (state == IDLE && rx_fire_c) begin
            addr_d = rx_data[6:0];
            if (!rx_data[7]) begin
                if (cmd_ok_c) begin
                    rdreq_bus_d = N'(1) << rx_data[6:0];
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        if (state == WAIT_DATA && rx_fire_c) begin
            master_data_d = rx_data;
            if (addr_ok_c) begin
                valid_bus_d = N'(1) << addr;
            end else begin
                err_d = 1'b1;
            end
        end

        // slave_data is valid during READ because rdreq_bus is asserted in that cycle.
        if (state == READ) begin
            tx_data_d = addr_ok_c ? slave_data : 8'hFF;
        end

        if (timeout_c) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_ready    <= 1'b0;
            tx_valid    <= 1'b0;
            valid_bus   <= '0;
            rdreq_bus   <= '0;
            err         <= 1'b0;
            addr        <= '0;
            master_data <= 8'h00;
            tx_data     <= 8'h00;
        end else begin
            rx_ready    <= rx_ready_d;
            tx_valid    <= tx_valid_d;
            valid_bus   <= valid_bus_d;
            rdreq_bus   <= rdreq_bus_d;
            err         <= err_d;
            addr        <= addr_d;
            master_data <= master_data_d;
            tx_data     <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_regs_cmd_parser.sv
// Directed bench for regs_cmd_parser: writes, backpressured reads, out-of-range, timeout, reset mid-frame.
module tb_regs_cmd_parser;

    localparam int unsigned N = 26;

    logic         clk;
    logic         n_rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   master_data;
    logic [N-1:0] valid_bus;
    logic [N-1:0] rdreq_bus;
    logic [7:0]   slave_data;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         err;

    int tests = 0;
    int fails = 0;
    int err_pulses = 0;
    int strobe_viol = 0;
    int exp_err_pulses = 0;

    regs_cmd_parser #(.N(N), .TIMEOUT(16)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .master_data (master_data),
        .valid_bus   (valid_bus),
        .rdreq_bus   (rdreq_bus),
        .slave_data  (slave_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .err         (err)
    );

    // Register file read model: slot 11 holds 8'h7F, slot 4 holds 8'h44.
    assign slave_data = rdreq_bus[11] ? 8'h7F : (rdreq_bus[4] ? 8'h44 : 8'h00);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(valid_bus | rdreq_bus) > 1) strobe_viol++;
        if (err) err_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_rst    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'h0);
        check("rst_master_data", 32'(master_data), 32'h0);
        check("rst_valid_bus", 32'(valid_bus), 32'h0);
        check("rst_rdreq_bus", 32'(rdreq_bus), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        n_rst = 1'b1;
        #1;
        check("rel_rx_ready_low", 32'(rx_ready), 32'h0);
        step();
        check("rel_rx_ready_high", 32'(rx_ready), 32'h1);

        // Write 8'h01 to slot 5
        rx_valid = 1'b1;
        rx_data  = 8'h85;
        step();
        check("wr_no_early_strobe", 32'(valid_bus), 32'h0);
        check("wr_wait_rx_ready", 32'(rx_ready), 32'h1);
        rx_data = 8'h01;
        step();
        rx_valid = 1'b0;
        check("wr_valid_bus", 32'(valid_bus), 32'h0000_0020);
        check("wr_master_data", 32'(master_data), 32'h01);
        check("wr_err", 32'(err), 32'h0);
        check("wr_rx_ready_low", 32'(rx_ready), 32'h0);
        step();
        check("wr_strobe_one_cycle", 32'(valid_bus), 32'h0);
        check("wr_back_idle", 32'(rx_ready), 32'h1);
        check("wr_data_hold", 32'(master_data), 32'h01);

        // Read slot 11 with 10 cycles of backpressure
        rx_valid = 1'b1;
        rx_data  = 8'h0B;
        step();
        rx_valid = 1'b0;
        check("rd_rdreq_bus", 32'(rdreq_bus), 32'h0000_0800);
        check("rd_err", 32'(err), 32'h0);
        check("rd_rx_ready_low", 32'(rx_ready), 32'h0);
        step();
        check("rd_rdreq_one_cycle", 32'(rdreq_bus), 32'h0);
        for (int i = 0; i < 10; i++) begin
            check("rd_backpressure", {23'h0, tx_valid, tx_data, rx_ready}, {23'h0, 1'b1, 8'h7F, 1'b0});
            step();
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("rd_tx_valid_drop", 32'(tx_valid), 32'h0);
        check("rd_idle_rx_ready", 32'(rx_ready), 32'h1);
        check("rd_tx_data_hold", 32'(tx_data), 32'h7F);

        // Out-of-range write: data consumed, no strobe, err pulse
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        step();
        rx_data = 8'h55;
        step();
        rx_valid = 1'b0;
        check("oor_wr_valid_bus", 32'(valid_bus), 32'h0);
        check("oor_wr_err", 32'(err), 32'h1);
        check("oor_wr_master_data", 32'(master_data), 32'h55);
        exp_err_pulses++;
        step();
        check("oor_wr_err_pulse", 32'(err), 32'h0);
        check("oor_wr_idle", 32'(rx_ready), 32'h1);

        // Out-of-range read: 8'hFF response, err pulse
        rx_valid = 1'b1;
        rx_data  = 8'h40;
        step();
        rx_valid = 1'b0;
        check("oor_rd_rdreq_bus", 32'(rdreq_bus), 32'h0);
        check("oor_rd_err", 32'(err), 32'h1);
        exp_err_pulses++;
        step();
        check("oor_rd_tx", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hFF});
        check("oor_rd_err_pulse", 32'(err), 32'h0);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("oor_rd_done", 32'(tx_valid), 32'h0);

`ifdef REGS_CMD_TIMEOUT_EN
        // Timeout after 16 idle cycles in WAIT_DATA
        rx_valid = 1'b1;
        rx_data  = 8'h84;
        step();
        rx_valid = 1'b0;
        repeat (15) step();
        check("tmo_not_yet", 32'(err), 32'h0);
        step();
        check("tmo_err", 32'(err), 32'h1);
        check("tmo_no_write", 32'(valid_bus), 32'h0);
        exp_err_pulses++;
        step();
        check("tmo_err_pulse", 32'(err), 32'h0);
        rx_valid = 1'b1;
        rx_data  = 8'h04;
        step();
        rx_valid = 1'b0;
        check("tmo_read_slot4", 32'(rdreq_bus), 32'h0000_0010);
        step();
        check("tmo_read_data", 32'(tx_data), 32'h44);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
`else
        // Without the timeout WAIT_DATA holds indefinitely
        rx_valid = 1'b1;
        rx_data  = 8'h84;
        step();
        rx_valid = 1'b0;
        repeat (20) step();
        check("notmo_err", 32'(err), 32'h0);
        check("notmo_rx_ready", 32'(rx_ready), 32'h1);
        rx_valid = 1'b1;
        rx_data  = 8'h3C;
        step();
        rx_valid = 1'b0;
        check("notmo_valid_bus", 32'(valid_bus), 32'h0000_0010);
        check("notmo_master_data", 32'(master_data), 32'h3C);
        step();
`endif

        // Reset in the middle of a write frame
        rx_valid = 1'b1;
        rx_data  = 8'h87;
        step();
        rx_valid = 1'b0;
        n_rst    = 1'b0;
        #1;
        check("mid_rst_outputs", {master_data, tx_data, 5'h0, tx_valid, err, rx_ready},
              {8'h00, 8'h00, 5'h0, 1'b0, 1'b0, 1'b0});
        check("mid_rst_strobes", 32'(valid_bus | rdreq_bus), 32'h0);
        step();
        n_rst = 1'b1;
        step();
        check("mid_rst_rel_ready", 32'(rx_ready), 32'h1);
        check("mid_rst_no_write", 32'(valid_bus), 32'h0);
        rx_valid = 1'b1;
        rx_data  = 8'h86;
        step();
        rx_data = 8'h00;
        step();
        rx_valid = 1'b0;
        check("mid_rst_valid_bus", 32'(valid_bus), 32'h0000_0040);
        check("mid_rst_master_data", 32'(master_data), 32'h00);
        step();
        check("mid_rst_strobe_once", 32'(valid_bus), 32'h0);

        step();
        check("strobe_exclusive", 32'(strobe_viol), 32'h0);
        check("err_pulse_count", 32'(err_pulses), 32'(exp_err_pulses));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
